// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer.
//   btn_state_t        : per-channel debounce FSM state
//   C_DEBOUNCE_DEFAULT : default stability window (10 ms at 100 MHz)
//   clog2()            : ceiling log2 for sizing the stability timer
package button_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  localparam int C_DEBOUNCE_DEFAULT = 1000000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, stability timer, FSM and
// registered press/release pulses.
//   Clock, Reset     : system clock, async active-high reset
//   i_button         : raw pin level, 1 = pressed
//   o_state          : debounced level
//   o_pressed        : one-cycle pulse on accepted 0->1
//   o_released       : one-cycle pulse on accepted 1->0
//   o_pressed_next   : value o_pressed takes at the next edge (feeds the
//                      press counter so it updates with the pulse)
//
// state     | meaning
// IDLE_LOW  | accepted level 0, input agrees
// WAIT_HIGH | accepted level 0, input has been 1 for r_timer samples
// IDLE_HIGH | accepted level 1, input agrees
// WAIT_LOW  | accepted level 1, input has been 0 for r_timer samples
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_button,
  output logic o_state,
  output logic o_pressed,
  output logic o_released,
  output logic o_pressed_next
);

  localparam int              TW     = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0]   C_TERM = TW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0]   C_ONE  = TW'(1);

  logic          r_sync1, r_sync2;
  btn_state_t    r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [TW-1:0] w_timer_inc;
  logic          r_pressed, r_released;
  logic          w_level_cur, w_level_next;
  logic          w_pressed_next, w_released_next;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= IDLE_LOW;
      r_timer    <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_sync1    <= i_button;
      r_sync2    <= r_sync1;
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_pressed  <= w_pressed_next;
      r_released <= w_released_next;
    end
  end

  // Timer holds the count of agreeing samples seen so far; the change is
  // accepted on the edge where that count would reach DEBOUNCE_CYCLES, which
  // gives a pin-to-State latency of 2 + DEBOUNCE_CYCLES edges.
  assign w_timer_inc = r_timer + C_ONE;

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync2) begin
          if (C_ONE == C_TERM) begin
            w_state_next = IDLE_HIGH;
            w_timer_next = '0;
          end else begin
            w_state_next = WAIT_HIGH;
            w_timer_next = C_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_next = IDLE_LOW;
          w_timer_next = '0;
        end else if (w_timer_inc == C_TERM) begin
          w_state_next = IDLE_HIGH;
          w_timer_next = '0;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      IDLE_HIGH: begin
        if (!r_sync2) begin
          if (C_ONE == C_TERM) begin
            w_state_next = IDLE_LOW;
            w_timer_next = '0;
          end else begin
            w_state_next = WAIT_LOW;
            w_timer_next = C_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_next = IDLE_HIGH;
          w_timer_next = '0;
        end else if (w_timer_inc == C_TERM) begin
          w_state_next = IDLE_LOW;
          w_timer_next = '0;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_timer_next = '0;
      end
    endcase
  end

  assign w_level_cur     = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);
  assign w_level_next    = (w_state_next == IDLE_HIGH) || (w_state_next == WAIT_LOW);
  assign w_pressed_next  = w_level_next & ~w_level_cur;
  assign w_released_next = ~w_level_next & w_level_cur;

  assign o_state        = w_level_cur;
  assign o_pressed      = r_pressed;
  assign o_released     = r_released;
  assign o_pressed_next = w_pressed_next;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH raw button pins and counts accepted presses.
//   Clock, Reset : system clock, async active-high reset
//   Buttons      : raw pin levels, 1 = pressed
//   ClearCount   : synchronous clear of PressCount
//   State        : debounced level per channel
//   Pressed      : one-cycle pulse per accepted press
//   Released     : one-cycle pulse per accepted release
//   PressCount   : running total of presses over all channels (wraps)
module button_debouncer
  import button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_DEFAULT,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       Buttons,
  input  logic                   ClearCount,
  output logic [WIDTH-1:0]       State,
  output logic [WIDTH-1:0]       Pressed,
  output logic [WIDTH-1:0]       Released,
  output logic [COUNT_WIDTH-1:0] PressCount
);

  logic [WIDTH-1:0]       w_pressed_next;
  logic [COUNT_WIDTH-1:0] w_popcount;
  logic [COUNT_WIDTH-1:0] r_count;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .Clock         (Clock),
      .Reset         (Reset),
      .i_button      (Buttons[g]),
      .o_state       (State[g]),
      .o_pressed     (Pressed[g]),
      .o_released    (Released[g]),
      .o_pressed_next(w_pressed_next[g])
    );
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcount = w_popcount + COUNT_WIDTH'(w_pressed_next[i]);
    end
  end

  // Clear only drops the old total; presses landing on the same edge still count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else begin
      r_count <= (ClearCount ? '0 : r_count) + w_popcount;
    end
  end

  assign PressCount = r_count;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [W-1:0]  Buttons = '0;
  logic          ClearCount = 1'b0;
  logic [W-1:0]  State, Pressed, Released;
  logic [CW-1:0] PressCount;

  int n_vec = 0;
  int n_err = 0;

  // reference model: accepted level flips once D consecutive synchronised
  // samples (pin delayed by two edges) disagree with it
  logic [W-1:0]  m_lvl, m_pr, m_rl;
  logic [CW-1:0] m_cnt;
  int            m_run[W];
  logic [W-1:0]  m_dq[$];

  button_debouncer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Buttons(Buttons), .ClearCount(ClearCount),
    .State(State), .Pressed(Pressed), .Released(Released), .PressCount(PressCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_pr = '0; m_rl = '0; m_cnt = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_dq = '{4'b0, 4'b0};
  endtask

  task automatic model_edge(input logic [W-1:0] pin, input logic clr);
    logic [W-1:0] s;
    s = m_dq.pop_front();
    m_dq.push_back(pin);
    m_pr = '0; m_rl = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
          if (s[i]) m_pr[i] = 1'b1; else m_rl[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_cnt = (clr ? '0 : m_cnt) + CW'($countones(m_pr));
  endtask

  // one clock edge: model follows the inputs held across the edge, then compare
  task automatic step();
    logic [W-1:0] pin;
    logic         clr;
    pin = Buttons; clr = ClearCount;
    @(posedge Clock);
    #1;
    model_edge(pin, clr);
    chk("state",    32'(State),      32'(m_lvl));
    chk("pressed",  32'(Pressed),    32'(m_pr));
    chk("released", 32'(Released),   32'(m_rl));
    chk("count",    32'(PressCount), 32'(m_cnt));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_state",    32'(State),      32'd0);
    chk("rst_pressed",  32'(Pressed),    32'd0);
    chk("rst_released", 32'(Released),   32'd0);
    chk("rst_count",    32'(PressCount), 32'd0);
    repeat (2) @(posedge Clock);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic hold_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int rate;
    model_reset();
    do_reset();

    // clean press on channel 0
    Buttons = 4'b0001;
    hold_steps(5);
    chk("clean_before", 32'(State[0]), 32'd0);
    step();
    chk("clean_state",   32'(State[0]),   32'd1);
    chk("clean_pressed", 32'(Pressed[0]), 32'd1);
    chk("clean_count",   32'(PressCount), 32'd1);
    step();
    chk("clean_pulse_end", 32'(Pressed[0]), 32'd0);

    // bounce on channel 1
    Buttons[1] = 1'b1; step();
    Buttons[1] = 1'b0; step();
    Buttons[1] = 1'b1; step();
    Buttons[1] = 1'b0; step();
    Buttons[1] = 1'b1;
    hold_steps(5);
    chk("bounce_before", 32'(Pressed[1]), 32'd0);
    step();
    chk("bounce_pressed", 32'(Pressed[1]), 32'd1);
    chk("bounce_count",   32'(PressCount), 32'd2);

    // simultaneous press from a clean reset
    Buttons = '0;
    do_reset();
    Buttons = 4'b1011;
    hold_steps(6);
    chk("simul_pressed", 32'(Pressed),    32'hb);
    chk("simul_count",   32'(PressCount), 32'd3);

    // bring count to 7, then clear on the edge that accepts channel 2
    Buttons = '0;    hold_steps(8);
    Buttons = 4'b1011; hold_steps(8);
    Buttons = '0;    hold_steps(8);
    Buttons = 4'b0001; hold_steps(8);
    chk("clr_pre_count", 32'(PressCount), 32'd7);
    Buttons = 4'b0101;
    hold_steps(5);
    ClearCount = 1'b1;
    step();
    ClearCount = 1'b0;
    chk("clr_pressed", 32'(Pressed[2]), 32'd1);
    chk("clr_count",   32'(PressCount), 32'd1);

    // reset two cycles into WAIT_HIGH with the button held
    Buttons = '0;
    do_reset();
    Buttons = 4'b0001;
    hold_steps(4);
    do_reset();
    hold_steps(5);
    chk("rstwait_before", 32'(Pressed[0]), 32'd0);
    step();
    chk("rstwait_pressed", 32'(Pressed[0]), 32'd1);
    chk("rstwait_count",   32'(PressCount), 32'd1);

    // wrap of the 4-bit counter: 16 presses on channel 3
    Buttons = '0;
    do_reset();
    for (int p = 0; p < 16; p++) begin
      Buttons[3] = 1'b1; hold_steps(6);
      chk("wrap_pressed", 32'(Pressed[3]), 32'd1);
      if (p < 15) begin
        Buttons[3] = 1'b0; hold_steps(8);
      end
    end
    chk("wrap_count", 32'(PressCount), 32'd0);
    Buttons[3] = 1'b0;
    hold_steps(6);
    chk("wrap_released", 32'(Released[3]), 32'd1);

    // randomized traffic with varying bounce density
    for (int seg = 0; seg < 40; seg++) begin
      rate = $urandom_range(1, 20);
      for (int c = 0; c < 50; c++) begin
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, rate) == 0) Buttons[i] = ~Buttons[i];
        ClearCount = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    ClearCount = 1'b0;
    do_reset();
    hold_steps(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
